// File: rtl/mod12_load_arbiter_pkg.sv
// Shared types and constants for the mod-12 load arbiter.
// Covers the FSM state encoding, the counter width and the preset range helper.
package mod12_load_arbiter_pkg;

  localparam int MOD_DEFAULT = 12;
  localparam int CNT_W       = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_REJECT,
    ST_LOAD,
    ST_VERIFY,
    ST_GAP
  } state_t;

  // A preset is usable only if the counter can actually hold it.
  function automatic logic preset_in_range(input logic [CNT_W-1:0] value, input int modulus);
    return int'(value) < modulus;
  endfunction

endpackage

// File: rtl/mod12_load_arbiter_if.sv
// Requester-side bundle of the load arbiter: requests, presets, responses,
// and the counter observation signals.
interface mod12_load_arbiter_if;
  import mod12_load_arbiter_pkg::*;

  logic [1:0]       req;
  logic [CNT_W-1:0] din0;
  logic [CNT_W-1:0] din1;
  logic [1:0]       ack;
  logic [1:0]       err;
  logic             busy;
  logic [CNT_W-1:0] count;
  logic             wrap;

  modport master (
    output req, din0, din1,
    input  ack, err, busy, count, wrap
  );

  modport slave (
    input  req, din0, din1,
    output ack, err, busy, count, wrap
  );

endinterface

// File: rtl/mod12_load_arbiter_mod_12.sv
// Loadable modulo counter. It runs freely from 0 to MOD-1 and jumps to din
// whenever load is high.
module mod_12
  import mod12_load_arbiter_pkg::*;
#(
  parameter int MOD = MOD_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] din,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MOD - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= din;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mod12_load_arbiter.sv
// Round-robin arbiter that gives two requesters access to the load port of a
// shared mod-12 counter. It range-checks and verifies each load, and it
// reports wrap events.
module mod12_load_arbiter
  import mod12_load_arbiter_pkg::*;
#(
  parameter int GAP = 2,
  parameter int MOD = MOD_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  mod12_load_arbiter_if.slave bus
);

  localparam logic [3:0]       GAP_INIT = 4'(GAP - 1);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(MOD - 1);

  state_t           state_reg, state_next;
  logic             sel_reg, sel_next;
  logic [CNT_W-1:0] d_lat_reg, d_lat_next;
  logic             last_grant_reg, last_grant_next;
  logic [3:0]       gap_cnt_reg, gap_cnt_next;
  logic [CNT_W-1:0] prev_count_reg;
  logic             prev_load_reg;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_din;
  logic [CNT_W-1:0] count_val;
  logic [1:0]       ack_c;
  logic [1:0]       err_c;

  mod_12 #(.MOD(MOD)) u_counter (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .din   (cnt_din),
    .count (count_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      sel_reg        <= 1'b0;
      d_lat_reg      <= '0;
      last_grant_reg <= 1'b1;
      gap_cnt_reg    <= '0;
      prev_count_reg <= '0;
      prev_load_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sel_reg        <= sel_next;
      d_lat_reg      <= d_lat_next;
      last_grant_reg <= last_grant_next;
      gap_cnt_reg    <= gap_cnt_next;
      prev_count_reg <= count_val;
      prev_load_reg  <= cnt_load;
    end
  end

  always_comb begin
    state_next      = state_reg;
    sel_next        = sel_reg;
    d_lat_next      = d_lat_reg;
    last_grant_next = last_grant_reg;
    gap_cnt_next    = gap_cnt_reg;
    cnt_load        = 1'b0;
    cnt_din         = '0;
    ack_c           = 2'b00;
    err_c           = 2'b00;

    case (state_reg)
      ST_IDLE: begin
        if (bus.req != 2'b00) begin
          // The round-robin pointer moves only when both requesters compete.
          if (bus.req == 2'b11) begin
            sel_next        = ~last_grant_reg;
            last_grant_next = ~last_grant_reg;
          end else begin
            sel_next = bus.req[1];
          end
          d_lat_next = sel_next ? bus.din1 : bus.din0;
          state_next = ST_ARB;
        end
      end
      ST_ARB: begin
        state_next = preset_in_range(d_lat_reg, MOD) ? ST_LOAD : ST_REJECT;
      end
      ST_REJECT: begin
        err_c[sel_reg] = 1'b1;
        gap_cnt_next   = GAP_INIT;
        state_next     = ST_GAP;
      end
      ST_LOAD: begin
        cnt_load   = 1'b1;
        cnt_din    = d_lat_reg;
        state_next = ST_VERIFY;
      end
      ST_VERIFY: begin
        if (count_val == d_lat_reg) begin
          ack_c[sel_reg] = 1'b1;
        end else begin
          err_c[sel_reg] = 1'b1;
        end
        gap_cnt_next = GAP_INIT;
        state_next   = ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt_reg == 4'd0) begin
          state_next = ST_IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg - 4'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // A load landing on 0 from MOD-1 is not a free-running wrap.
  assign bus.wrap  = (prev_count_reg == LAST) && (count_val == '0) && !prev_load_reg;
  assign bus.ack   = ack_c;
  assign bus.err   = err_c;
  assign bus.busy  = (state_reg != ST_IDLE);
  assign bus.count = count_val;

endmodule

// File: tb/tb_mod12_load_arbiter.sv
// Directed bench for mod12_load_arbiter with GAP=2. Each scenario task
// drives its stimulus and checks the results cycle by cycle.
module tb_mod12_load_arbiter;
  import mod12_load_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  mod12_load_arbiter_if bus_if ();

  mod12_load_arbiter #(.GAP(2), .MOD(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus_if.busy !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (bus_if.busy !== 1'b0) begin
      failures++;
      $display("FAIL wait_idle: busy=%b required=0 after %0d cycles", bus_if.busy, n);
    end
  endtask

  task automatic test_reset();
    int n;
    bus_if.req = 2'b00; bus_if.din0 = '0; bus_if.din1 = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got=%b exp=0", bus_if.busy); end
    checks++; if (bus_if.ack !== 2'b00) begin failures++; $display("FAIL reset_ack: got=%b exp=00", bus_if.ack); end
    checks++; if (bus_if.err !== 2'b00) begin failures++; $display("FAIL reset_err: got=%b exp=00", bus_if.err); end
    checks++; if (bus_if.count !== 4'd0) begin failures++; $display("FAIL reset_count: got=%0d exp=0", bus_if.count); end
    checks++; if (bus_if.wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap: got=%b exp=0", bus_if.wrap); end
    checks++; if (dut.state_reg !== ST_IDLE) begin failures++; $display("FAIL reset_state: got=%0d exp=%0d", dut.state_reg, ST_IDLE); end
    n = 0;
    while (bus_if.count !== 4'd11 && n < 20) begin
      tick();
      n++;
    end
    checks++; if (n !== 11) begin failures++; $display("FAIL reset_run_to_11: cycles=%0d exp=11", n); end
    tick();
    checks++; if (bus_if.count !== 4'd0) begin failures++; $display("FAIL wrap_count: got=%0d exp=0", bus_if.count); end
    checks++; if (bus_if.wrap !== 1'b1) begin failures++; $display("FAIL wrap_pulse: got=%b exp=1", bus_if.wrap); end
    tick();
    checks++; if (bus_if.wrap !== 1'b0) begin failures++; $display("FAIL wrap_one_cycle: got=%b exp=0", bus_if.wrap); end
    checks++; if (bus_if.count !== 4'd1) begin failures++; $display("FAIL wrap_next_count: got=%0d exp=1", bus_if.count); end
  endtask

  task automatic test_single_load();
    wait_idle();
    bus_if.din0 = 4'd7; bus_if.req = 2'b01;
    tick();
    checks++; if (bus_if.busy !== 1'b1) begin failures++; $display("FAIL single_busy: got=%b exp=1", bus_if.busy); end
    tick();
    checks++; if (dut.cnt_load !== 1'b1) begin failures++; $display("FAIL single_load_strobe: got=%b exp=1", dut.cnt_load); end
    tick();
    checks++; if (bus_if.count !== 4'd7) begin failures++; $display("FAIL single_count: got=%0d exp=7", bus_if.count); end
    checks++; if (bus_if.ack !== 2'b01) begin failures++; $display("FAIL single_ack: got=%b exp=01", bus_if.ack); end
    checks++; if (bus_if.err !== 2'b00) begin failures++; $display("FAIL single_err: got=%b exp=00", bus_if.err); end
    tick();
    bus_if.req = 2'b00;
    checks++; if (bus_if.count !== 4'd8) begin failures++; $display("FAIL single_count_next: got=%0d exp=8", bus_if.count); end
    checks++; if (bus_if.ack !== 2'b00) begin failures++; $display("FAIL single_ack_pulse: got=%b exp=00", bus_if.ack); end
    tick();
    checks++; if (bus_if.busy !== 1'b1) begin failures++; $display("FAIL single_gap_busy: got=%b exp=1", bus_if.busy); end
    tick();
    checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL single_idle: got=%b exp=0", bus_if.busy); end
  endtask

  task automatic test_range_reject();
    logic [3:0] c1;
    wait_idle();
    bus_if.din1 = 4'd13; bus_if.req = 2'b10;
    tick();
    c1 = bus_if.count;
    tick();
    checks++; if (bus_if.err !== 2'b10) begin failures++; $display("FAIL reject_err: got=%b exp=10", bus_if.err); end
    checks++; if (bus_if.ack !== 2'b00) begin failures++; $display("FAIL reject_ack: got=%b exp=00", bus_if.ack); end
    checks++; if (dut.cnt_load !== 1'b0) begin failures++; $display("FAIL reject_no_load: got=%b exp=0", dut.cnt_load); end
    checks++;
    if (bus_if.count !== ((c1 == 4'd11) ? 4'd0 : c1 + 4'd1)) begin
      failures++; $display("FAIL reject_free_run: got=%0d prev=%0d", bus_if.count, c1);
    end
    tick();
    bus_if.req = 2'b00;
    checks++; if (bus_if.err !== 2'b00) begin failures++; $display("FAIL reject_err_pulse: got=%b exp=00", bus_if.err); end
    tick(); tick();
    checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL reject_idle: got=%b exp=0", bus_if.busy); end
  endtask

  task automatic test_tie();
    wait_idle();
    bus_if.din0 = 4'd3; bus_if.din1 = 4'd9; bus_if.req = 2'b11;
    tick(); tick(); tick();
    checks++; if (bus_if.ack !== 2'b01) begin failures++; $display("FAIL tie1_first_ack: got=%b exp=01", bus_if.ack); end
    checks++; if (bus_if.count !== 4'd3) begin failures++; $display("FAIL tie1_first_count: got=%0d exp=3", bus_if.count); end
    tick();
    bus_if.req = 2'b10;
    tick(); tick(); tick(); tick(); tick();
    checks++; if (bus_if.ack !== 2'b10) begin failures++; $display("FAIL tie1_second_ack: got=%b exp=10", bus_if.ack); end
    checks++; if (bus_if.count !== 4'd9) begin failures++; $display("FAIL tie1_second_count: got=%0d exp=9", bus_if.count); end
    tick();
    bus_if.req = 2'b00;
    wait_idle();
    bus_if.din0 = 4'd4; bus_if.din1 = 4'd6; bus_if.req = 2'b11;
    tick(); tick(); tick();
    checks++; if (bus_if.ack !== 2'b10) begin failures++; $display("FAIL tie2_first_ack: got=%b exp=10", bus_if.ack); end
    checks++; if (bus_if.count !== 4'd6) begin failures++; $display("FAIL tie2_first_count: got=%0d exp=6", bus_if.count); end
    tick();
    bus_if.req = 2'b01;
    tick(); tick(); tick(); tick(); tick();
    checks++; if (bus_if.ack !== 2'b01) begin failures++; $display("FAIL tie2_second_ack: got=%b exp=01", bus_if.ack); end
    checks++; if (bus_if.count !== 4'd4) begin failures++; $display("FAIL tie2_second_count: got=%0d exp=4", bus_if.count); end
    tick();
    bus_if.req = 2'b00;
  endtask

  task automatic test_mid_reset();
    wait_idle();
    bus_if.din0 = 4'd5; bus_if.req = 2'b01;
    tick(); tick();
    checks++; if (dut.cnt_load !== 1'b1) begin failures++; $display("FAIL midrst_in_load: got=%b exp=1", dut.cnt_load); end
    rst = 1'b1;
    tick();
    checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got=%b exp=0", bus_if.busy); end
    checks++; if (bus_if.ack !== 2'b00 || bus_if.err !== 2'b00) begin
      failures++; $display("FAIL midrst_resp: ack=%b err=%b exp=00/00", bus_if.ack, bus_if.err);
    end
    checks++; if (bus_if.count !== 4'd0) begin failures++; $display("FAIL midrst_count: got=%0d exp=0", bus_if.count); end
    rst = 1'b0;
    tick(); tick(); tick();
    checks++; if (bus_if.ack !== 2'b01) begin failures++; $display("FAIL midrst_regrant_ack: got=%b exp=01", bus_if.ack); end
    checks++; if (bus_if.count !== 4'd5) begin failures++; $display("FAIL midrst_regrant_count: got=%0d exp=5", bus_if.count); end
    tick();
    bus_if.req = 2'b00;
  endtask

  task automatic test_load_at_wrap();
    int n;
    wait_idle();
    n = 0;
    while (bus_if.count !== 4'd9 && n < 30) begin
      tick();
      n++;
    end
    checks++; if (bus_if.count !== 4'd9) begin failures++; $display("FAIL lwrap_align: got=%0d exp=9", bus_if.count); end
    bus_if.din0 = 4'd0; bus_if.req = 2'b01;
    tick(); tick();
    checks++; if (bus_if.count !== 4'd11 || dut.cnt_load !== 1'b1) begin
      failures++; $display("FAIL lwrap_load_cycle: count=%0d load=%b exp=11/1", bus_if.count, dut.cnt_load);
    end
    tick();
    checks++; if (bus_if.ack !== 2'b01) begin failures++; $display("FAIL lwrap_ack: got=%b exp=01", bus_if.ack); end
    checks++; if (bus_if.count !== 4'd0) begin failures++; $display("FAIL lwrap_count: got=%0d exp=0", bus_if.count); end
    checks++; if (bus_if.wrap !== 1'b0) begin failures++; $display("FAIL lwrap_no_wrap: got=%b exp=0", bus_if.wrap); end
    tick();
    bus_if.req = 2'b00;
    checks++; if (bus_if.count !== 4'd1 || bus_if.wrap !== 1'b0) begin
      failures++; $display("FAIL lwrap_after: count=%0d wrap=%b exp=1/0", bus_if.count, bus_if.wrap);
    end
  endtask

  initial begin
    bus_if.req  = 2'b00;
    bus_if.din0 = '0;
    bus_if.din1 = '0;
    test_reset();
    test_single_load();
    test_range_reject();
    test_tie();
    test_mid_reset();
    test_load_at_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
